prime_ticker: RTL



---
 rtl/primogen_pkg.sv | 29 ++
 rtl/prime_ticker_tick_gen.sv | 37 +++
 rtl/prime_ticker.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/primogen_pkg.sv
// Shared definitions for the prime_ticker sequencer and its tick divider.
// Holds the sequencer state encoding, the divider sizing helpers and the
// result width used by the primogen prime generator.
package primogen_pkg;

    // Result width of the primogen generator; prime_ticker defaults to it.
    localparam int unsigned PG_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_IDLE = 3'd1,
        ST_REQ  = 3'd2,
        ST_WAIT = 3'd3,
        ST_HOLD = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

    // Board clocks per advance tick.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Divider counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/prime_ticker_tick_gen.sv
// Free-running tick divider for prime_ticker. Counts 0..DIV-1 and pulses
// tick for one cycle on the last count, then wraps to 0.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset (counter returns to 0)
//   tick  - one-cycle pulse every DIV clocks
module tick_gen
    import primogen_pkg::*;
#(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned    W    = cnt_width(DIV);
    localparam logic [W-1:0]   LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prime_ticker.sv
// Board sequencer between the primogen generator and the LEDs. Issues a
// go pulse per tick, latches each result, counts primes, restarts or halts
// on generator overflow and drives a mode-selectable LED display.
// Ports:
//   clk, rst_n        - system clock, asynchronous active-low reset
//   pause             - hold off new requests (pending tick is kept)
//   mode              - LED source: 0 = prime, 1 = count
//   pg_go, pg_rst     - request pulse and active-high reset to the generator
//   pg_ready, pg_error, pg_res - generator handshake and result
//   prime, prime_valid, count  - last result, its validity, primes latched
//   err_flag          - high while in the error state
//   led               - display output
//
// state | meaning
// RST   | generator held in reset for one cycle
// IDLE  | wait for generator idle and no pause
// REQ   | pg_go asserted this cycle
// WAIT  | first cycle blanked, then wait for pg_ready
// HOLD  | result latched, wait for a tick to request the next one
// ERR   | generator overflowed; blink LEDs, restart on tick or halt
module prime_ticker
    import primogen_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 12000000,
    parameter int unsigned TICK_HZ      = 1,
    parameter int unsigned WIDTH        = PG_WIDTH,
    parameter int unsigned NLEDS        = 5,
    parameter int unsigned CW           = 16,
    parameter bit          AUTO_RESTART = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pause,
    input  logic             mode,
    output logic             pg_go,
    output logic             pg_rst,
    input  logic             pg_ready,
    input  logic             pg_error,
    input  logic [WIDTH-1:0] pg_res,
    output logic [WIDTH-1:0] prime,
    output logic             prime_valid,
    output logic [CW-1:0]    count,
    output logic             err_flag,
    output logic [NLEDS-1:0] led
);

    localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);

    logic             tick;
    state_e           state_q, state_d;
    logic             tick_pend_q;
    logic             blank_q;
    logic [WIDTH-1:0] prime_q;
    logic             prime_valid_q;
    logic [CW-1:0]    count_q;
    logic             pg_go_q;
    logic             pg_rst_q;
    logic             err_q;
    logic             blink_q;
    logic [NLEDS-1:0] led_q, led_d;

    logic latch, restart, enter_idle, leave_hold;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST:  state_d = ST_IDLE;
            ST_IDLE: if (pg_ready && !pause) state_d = ST_REQ;
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: if (!blank_q && pg_ready) state_d = pg_error ? ST_ERR : ST_HOLD;
            ST_HOLD: if ((tick || tick_pend_q) && !pause) state_d = ST_REQ;
            ST_ERR:  if (AUTO_RESTART && tick) state_d = ST_RST;
            default: state_d = ST_RST;
        endcase
    end

    assign latch      = (state_q == ST_WAIT) && (state_d == ST_HOLD);
    assign restart    = (state_q == ST_ERR)  && (state_d == ST_RST);
    assign enter_idle = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    assign leave_hold = (state_q == ST_HOLD) && (state_d == ST_REQ);

    // Count is zero-extended onto the LEDs when it is narrower than the display.
    always_comb begin
        led_d = '0;
        if (state_q == ST_ERR) begin
            led_d = {NLEDS{blink_q}};
        end else if (mode) begin
            for (int unsigned b = 0; b < NLEDS; b++) begin
                if (b < CW) led_d[b] = count_q[b];
            end
        end else begin
            led_d = prime_q[NLEDS-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RST;
            tick_pend_q   <= 1'b0;
            blank_q       <= 1'b0;
            prime_q       <= '0;
            prime_valid_q <= 1'b0;
            count_q       <= '0;
            pg_go_q       <= 1'b0;
            pg_rst_q      <= 1'b1;
            err_q         <= 1'b0;
            blink_q       <= 1'b0;
            led_q         <= '0;
        end else begin
            state_q  <= state_d;
            pg_go_q  <= (state_d == ST_REQ);
            pg_rst_q <= (state_d == ST_RST);
            err_q    <= (state_d == ST_ERR);
            // The cycle right after REQ ignores pg_ready: the generator has
            // not yet dropped its idle indication.
            blank_q  <= (state_q == ST_REQ);
            led_q    <= led_d;

            if (tick) blink_q <= ~blink_q;

            // Clearing wins over a coincident tick so a tick that launches
            // the request is consumed rather than stored.
            if (enter_idle || leave_hold) begin
                tick_pend_q <= 1'b0;
            end else if (tick) begin
                tick_pend_q <= 1'b1;
            end

            if (latch) begin
                prime_q       <= pg_res;
                prime_valid_q <= 1'b1;
                count_q       <= count_q + CW'(1);
            end else if (restart) begin
                count_q       <= '0;
                prime_valid_q <= 1'b0;
            end
        end
    end

    assign pg_go       = pg_go_q;
    assign pg_rst      = pg_rst_q;
    assign prime       = prime_q;
    assign prime_valid = prime_valid_q;
    assign count       = count_q;
    assign err_flag    = err_q;
    assign led         = led_q;

endmodule
